sync_fifo_cfg: RTL and testbench

- Parametrised next-generation synchronous FIFO for single-clock datapaths on the 100 MHz system clock.
- Adds the following over the basic FIFO:
  - selectable read mode: registered or first-word-fall-through (FWFT)
  - fill count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - synchronous flush
- Sits between producer/consumer blocks that need back-pressure with margin or zero-latency head access.

---
 rtl/sync_fifo_cfg.sv | 111 +++++++++++
 tb/tb_sync_fifo_cfg.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with selectable registered or first-word-fall-through read.
// Also provides a fill count, almost-full/empty thresholds, sticky error flags and a flush.
module sync_fifo_cfg #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int FWFT     = 0,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             sysclk_100M,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             write_en,
   input  logic [WIDTH-1:0] write_data,
   output logic             full,
   output logic             almost_full,
   input  logic             read_en,
   output logic [WIDTH-1:0] read_data,
   output logic             read_valid,
   output logic             empty,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;
   logic [CW-1:0]    count_nxt;

   // Explicit wrap so any DEPTH works, not only powers of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      wr_acc    = write_en && !full && !flush;
      rd_acc    = read_en && !empty && !flush;
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (wr_acc && !rd_acc) begin
         count_nxt = count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
         count_nxt = count - CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sysclk_100M or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         // Flags derive from the next count so they line up with it.
         count        <= count_nxt;
         empty        <= (count_nxt == '0);
         full         <= (count_nxt == CW'(DEPTH));
         almost_full  <= (count_nxt >= CW'(AF_LEVEL));
         almost_empty <= (count_nxt <= CW'(AE_LEVEL));
         if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
            if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
            if (write_en && full) overflow <= 1'b1;
            if (read_en && empty) underflow <= 1'b1;
         end
      end
   end

   // NOTE: storage has no reset; only pointers and count define which entries are valid.
   always_ff @(posedge sysclk_100M) begin
      if (wr_acc) mem[wr_ptr] <= write_data;
   end

   if (FWFT == 0) begin : g_reg_read
      always_ff @(posedge sysclk_100M or negedge rst_n) begin
         if (!rst_n) begin
            read_data  <= '0;
            read_valid <= 1'b0;
         end else begin
            read_valid <= rd_acc;
            if (rd_acc) read_data <= mem[rd_ptr];
         end
      end
   end else begin : g_fwft_read
      // Head word is presented directly; forced to zero while empty so reset output is defined.
      assign read_data  = empty ? '0 : mem[rd_ptr];
      assign read_valid = !empty;
   end

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Bench for sync_fifo_cfg: a registered-read and an FWFT instance share one stimulus
// stream; directed scenarios use literal expectations, the random run uses a queue model.
module tb_sync_fifo_cfg;

   localparam int DEPTH = 4;
   localparam int AFL   = 3;
   localparam int AEL   = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       write_en;
   logic [7:0] write_data;
   logic       read_en;

   logic       a_full, a_almost_full, a_read_valid, a_empty, a_almost_empty, a_overflow, a_underflow;
   logic [7:0] a_read_data;
   logic [2:0] a_count;
   logic       b_full, b_almost_full, b_read_valid, b_empty, b_almost_empty, b_overflow, b_underflow;
   logic [7:0] b_read_data;
   logic [2:0] b_count;
   logic [6:0] a_st;
   logic [6:0] b_st;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [7:0] m_q [$];
   bit         m_ovf;
   bit         m_unf;
   bit         m_rv;
   logic [7:0] m_rd;

   always #5 clk = ~clk;

   assign a_st = {a_empty, a_full, a_almost_empty, a_almost_full, a_overflow, a_underflow, a_read_valid};
   assign b_st = {b_empty, b_full, b_almost_empty, b_almost_full, b_overflow, b_underflow, b_read_valid};

   sync_fifo_cfg #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_reg (
      .sysclk_100M(clk), .rst_n(rst_n), .flush(flush),
      .write_en(write_en), .write_data(write_data),
      .full(a_full), .almost_full(a_almost_full),
      .read_en(read_en), .read_data(a_read_data), .read_valid(a_read_valid),
      .empty(a_empty), .almost_empty(a_almost_empty), .count(a_count),
      .overflow(a_overflow), .underflow(a_underflow)
   );

   sync_fifo_cfg #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) u_fwft (
      .sysclk_100M(clk), .rst_n(rst_n), .flush(flush),
      .write_en(write_en), .write_data(write_data),
      .full(b_full), .almost_full(b_almost_full),
      .read_en(read_en), .read_data(b_read_data), .read_valid(b_read_valid),
      .empty(b_empty), .almost_empty(b_almost_empty), .count(b_count),
      .overflow(b_overflow), .underflow(b_underflow)
   );

   function automatic void model_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = 8'h00;
   endfunction

   function automatic void model_step(input bit we, input logic [7:0] wd, input bit re, input bit fl);
      bit was_full;
      bit was_empty;
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      if (fl) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rv  = 1'b0;
      end else begin
         m_rv = re && !was_empty;
         if (m_rv) m_rd = m_q.pop_front();
         if (we && !was_full) m_q.push_back(wd);
         if (we && was_full) m_ovf = 1'b1;
         if (re && was_empty) m_unf = 1'b1;
      end
   endfunction

   // Expected status {empty, full, ae, af, ovf, unf, rv}; rv differs between read modes.
   function automatic logic [6:0] model_status(input bit fwft_mode);
      int n;
      n = m_q.size();
      return {n == 0, n == DEPTH, n <= AEL, n >= AFL, m_ovf, m_unf, fwft_mode ? (n != 0) : m_rv};
   endfunction

   // Drives one cycle of stimulus from a negedge and returns at the following negedge.
   task automatic tick(input bit we, input logic [7:0] wd, input bit re, input bit fl);
      write_en   = we;
      write_data = wd;
      read_en    = re;
      flush      = fl;
      @(posedge clk);
      model_step(we, wd, re, fl);
      @(negedge clk);
      write_en = 1'b0;
      read_en  = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; write_en = 1'b0; read_en = 1'b0; write_data = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (a_st !== 7'b1010000) begin errors++; $display("FAIL reset_status_reg got %b expected %b", a_st, 7'b1010000); end
      checks++;
      if (b_st !== 7'b1010000) begin errors++; $display("FAIL reset_status_fwft got %b expected %b", b_st, 7'b1010000); end
      checks++;
      if (a_count !== 3'd0 || a_read_data !== 8'h00 || b_read_data !== 8'h00) begin
         errors++; $display("FAIL reset_count_data got cnt=%0d rd=%h/%h expected 0 00/00", a_count, a_read_data, b_read_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill();
      logic [7:0] d   [5] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
      logic [2:0] cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      logic [6:0] st  [5] = '{7'b0010000, 7'b0000000, 7'b0001000, 7'b0101000, 7'b0101100};
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, d[i], 1'b0, 1'b0);
         checks++;
         if (a_count !== cnt[i]) begin errors++; $display("FAIL fill_count[%0d] got %0d expected %0d", i, a_count, cnt[i]); end
         checks++;
         if (a_st !== st[i]) begin errors++; $display("FAIL fill_status[%0d] got %b expected %b", i, a_st, st[i]); end
      end
   endtask

   task automatic test_drain();
      logic [7:0] d   [5] = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hdd};
      logic [2:0] cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
      logic [6:0] st  [5] = '{7'b0001101, 7'b0000101, 7'b0010101, 7'b1010101, 7'b1010110};
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            checks++;
            if (b_read_data !== d[i] || b_read_valid !== 1'b1) begin
               errors++; $display("FAIL drain_fwft_head[%0d] got %h/%b expected %h/1", i, b_read_data, b_read_valid, d[i]);
            end
         end
         tick(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (a_read_data !== d[i]) begin errors++; $display("FAIL drain_data[%0d] got %h expected %h", i, a_read_data, d[i]); end
         checks++;
         if (a_count !== cnt[i]) begin errors++; $display("FAIL drain_count[%0d] got %0d expected %0d", i, a_count, cnt[i]); end
         checks++;
         if (a_st !== st[i]) begin errors++; $display("FAIL drain_status[%0d] got %b expected %b", i, a_st, st[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] w1 [3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0] w2 [3] = '{8'h44, 8'h55, 8'h66};
      logic [7:0] r2 [4] = '{8'h33, 8'h44, 8'h55, 8'h66};
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (a_st !== 7'b1010000 || a_read_data !== 8'hdd) begin
         errors++; $display("FAIL wrap_flush got %b rd=%h expected 1010000 rd=dd", a_st, a_read_data);
      end
      for (int i = 0; i < 3; i++) tick(1'b1, w1[i], 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (a_read_data !== w1[i]) begin errors++; $display("FAIL wrap_early_read[%0d] got %h expected %h", i, a_read_data, w1[i]); end
      end
      for (int i = 0; i < 3; i++) tick(1'b1, w2[i], 1'b0, 1'b0);
      checks++;
      if (a_count !== 3'd4 || a_full !== 1'b1) begin
         errors++; $display("FAIL wrap_full got cnt=%0d full=%b expected 4 1", a_count, a_full);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (a_read_data !== r2[i]) begin errors++; $display("FAIL wrap_read[%0d] got %h expected %h", i, a_read_data, r2[i]); end
      end
   endtask

   task automatic test_simultaneous();
      logic [7:0] tail [3] = '{8'h8d, 8'h9e, 8'haf};
      tick(1'b1, 8'h5a, 1'b1, 1'b0);
      checks++;
      if (a_count !== 3'd1 || a_underflow !== 1'b1 || a_read_valid !== 1'b0) begin
         errors++; $display("FAIL simul_empty got cnt=%0d unf=%b rv=%b expected 1 1 0", a_count, a_underflow, a_read_valid);
      end
      tick(1'b1, 8'h6b, 1'b0, 1'b0);
      tick(1'b1, 8'h7c, 1'b1, 1'b0);
      checks++;
      if (a_count !== 3'd2 || a_read_data !== 8'h5a) begin
         errors++; $display("FAIL simul_mid1 got cnt=%0d rd=%h expected 2 5a", a_count, a_read_data);
      end
      tick(1'b1, 8'h8d, 1'b1, 1'b0);
      checks++;
      if (a_count !== 3'd2 || a_read_data !== 8'h6b) begin
         errors++; $display("FAIL simul_mid2 got cnt=%0d rd=%h expected 2 6b", a_count, a_read_data);
      end
      tick(1'b1, 8'h9e, 1'b0, 1'b0);
      tick(1'b1, 8'haf, 1'b0, 1'b0);
      tick(1'b1, 8'hff, 1'b1, 1'b0);
      checks++;
      if (a_count !== 3'd3 || a_read_data !== 8'h7c || a_overflow !== 1'b1 || a_full !== 1'b0) begin
         errors++; $display("FAIL simul_full got cnt=%0d rd=%h ovf=%b full=%b expected 3 7c 1 0", a_count, a_read_data, a_overflow, a_full);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0);
         checks++;
         if (a_read_data !== tail[i]) begin errors++; $display("FAIL simul_order[%0d] got %h expected %h", i, a_read_data, tail[i]); end
      end
   endtask

   task automatic test_fwft();
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      checks++;
      if (b_empty !== 1'b0 || b_read_valid !== 1'b1 || b_read_data !== 8'h55) begin
         errors++; $display("FAIL fwft_first got e=%b rv=%b rd=%h expected 0 1 55", b_empty, b_read_valid, b_read_data);
      end
      tick(1'b1, 8'h77, 1'b0, 1'b0);
      checks++;
      if (b_read_data !== 8'h55) begin errors++; $display("FAIL fwft_hold got %h expected 55", b_read_data); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (b_read_data !== 8'h77 || b_read_valid !== 1'b1 || b_count !== 3'd1) begin
         errors++; $display("FAIL fwft_pop got rd=%h rv=%b cnt=%0d expected 77 1 1", b_read_data, b_read_valid, b_count);
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (b_empty !== 1'b1 || b_read_valid !== 1'b0) begin
         errors++; $display("FAIL fwft_empty got e=%b rv=%b expected 1 0", b_empty, b_read_valid);
      end
   endtask

   task automatic test_flush();
      for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (a_count !== 3'd3 || a_overflow !== 1'b1 || a_read_data !== 8'h01) begin
         errors++; $display("FAIL flush_setup got cnt=%0d ovf=%b rd=%h expected 3 1 01", a_count, a_overflow, a_read_data);
      end
      tick(1'b1, 8'hee, 1'b0, 1'b1);
      checks++;
      if (a_count !== 3'd0 || a_st !== 7'b1010000 || a_read_data !== 8'h01) begin
         errors++; $display("FAIL flush_clear got cnt=%0d st=%b rd=%h expected 0 1010000 01", a_count, a_st, a_read_data);
      end
      tick(1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (a_underflow !== 1'b0 || b_underflow !== 1'b0) begin
         errors++; $display("FAIL flush_no_unf got %b/%b expected 0/0", a_underflow, b_underflow);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (a_count !== 3'd0 || b_empty !== 1'b1) begin
         errors++; $display("FAIL flush_write_ignored got cnt=%0d e=%b expected 0 1", a_count, b_empty);
      end
   endtask

   task automatic test_async_reset();
      tick(1'b1, 8'hc1, 1'b0, 1'b0);
      tick(1'b1, 8'hc2, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (a_count !== 3'd0 || a_empty !== 1'b1 || b_empty !== 1'b1 || a_read_data !== 8'h00 || b_read_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset got cnt=%0d e=%b/%b rd=%h rv=%b expected 0 1/1 00 0",
                            a_count, a_empty, b_empty, a_read_data, b_read_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(1'b1, 8'hd1, 1'b0, 1'b0);
      checks++;
      if (a_count !== 3'd1 || b_read_data !== 8'hd1) begin
         errors++; $display("FAIL async_resume got cnt=%0d rd=%h expected 1 d1", a_count, b_read_data);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
         checks++;
         if (a_count !== 3'(m_q.size()) || b_count !== 3'(m_q.size())) begin
            errors++; $display("FAIL rand_count[%0d] got %0d/%0d expected %0d", i, a_count, b_count, m_q.size());
         end
         checks++;
         if (a_st !== model_status(1'b0)) begin
            errors++; $display("FAIL rand_status_reg[%0d] got %b expected %b", i, a_st, model_status(1'b0));
         end
         checks++;
         if (b_st !== model_status(1'b1)) begin
            errors++; $display("FAIL rand_status_fwft[%0d] got %b expected %b", i, b_st, model_status(1'b1));
         end
         checks++;
         if (a_read_data !== m_rd) begin
            errors++; $display("FAIL rand_data_reg[%0d] got %h expected %h", i, a_read_data, m_rd);
         end
         if (b_read_valid === 1'b1 && m_q.size() != 0) begin
            checks++;
            if (b_read_data !== m_q[0]) begin
               errors++; $display("FAIL rand_data_fwft[%0d] got %h expected %h", i, b_read_data, m_q[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_fwft();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
